// File: rtl/pipelined_divider.sv
// Pipelined unsigned restoring divider: SLICES_PER_STAGE quotient bits per
// registered stage, valid/ready on both ends, bubble-collapsing advance.
module pipelined_divider #(
  parameter int unsigned DIVIDENDLEN      = 8,
  parameter int unsigned DIVISORLEN       = 4,
  parameter int unsigned SLICES_PER_STAGE = 2,
  parameter int unsigned TAGLEN           = 4
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIVIDENDLEN-1:0] dividend,
  input  logic [DIVISORLEN-1:0]  divisor,
  input  logic [TAGLEN-1:0]      in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIVIDENDLEN-1:0] quotient,
  output logic [DIVISORLEN-1:0]  remainder,
  output logic [TAGLEN-1:0]      out_tag,
  output logic                   div_by_zero
);

  localparam int unsigned DW      = DIVIDENDLEN;
  localparam int unsigned RW      = DIVISORLEN;
  localparam int unsigned NSTAGES = (DW + SLICES_PER_STAGE - 1) / SLICES_PER_STAGE;

  logic [NSTAGES-1:0] vld_d, vld_q, adv_c;

  // Element 0 is the input port, element k+1 is the register of stage k.
  logic [NSTAGES:0] chain_vld;
  logic [NSTAGES:0] chain_dz;
  logic [RW:0]      chain_prem [NSTAGES+1];
  logic [DW-1:0]    chain_dvd  [NSTAGES+1];
  logic [DW-1:0]    chain_quo  [NSTAGES+1];
  logic [RW-1:0]    chain_dvs  [NSTAGES+1];
  logic [TAGLEN-1:0] chain_tag [NSTAGES+1];

  assign chain_vld     = {vld_q, in_valid};
  assign chain_dz[0]   = (divisor == '0);
  assign chain_prem[0] = '0;
  assign chain_dvd[0]  = dividend;
  assign chain_quo[0]  = '0;
  assign chain_dvs[0]  = divisor;
  assign chain_tag[0]  = in_tag;

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    adv_c = '0;
    adv_c[NSTAGES-1] = !vld_q[NSTAGES-1] || out_ready;
    for (int k = int'(NSTAGES) - 2; k >= 0; k--) begin
      adv_c[k] = !vld_q[k] || adv_c[k+1];
    end
  end

  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < int'(NSTAGES); k++) begin
      if (adv_c[k]) vld_d[k] = chain_vld[k];
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) vld_q <= '0;
    else         vld_q <= vld_d;
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    logic [RW:0]       prem_d, prem_q;
    logic [DW-1:0]     dvd_d, dvd_q;
    logic [DW-1:0]     quo_d, quo_q;
    logic [RW-1:0]     dvs_d, dvs_q;
    logic [TAGLEN-1:0] tag_d, tag_q;
    logic              dz_d, dz_q;

    // Data only moves with a valid operation so idle outputs stay put.
    always_comb begin
      prem_d = prem_q;
      dvd_d  = dvd_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      tag_d  = tag_q;
      dz_d   = dz_q;
      if (adv_c[k] && chain_vld[k]) begin
        prem_d = chain_prem[k];
        dvd_d  = chain_dvd[k];
        quo_d  = chain_quo[k];
        dvs_d  = chain_dvs[k];
        tag_d  = chain_tag[k];
        dz_d   = chain_dz[k];
        for (int unsigned s = 0; s < SLICES_PER_STAGE; s++) begin
          if (k * SLICES_PER_STAGE + s < DW) begin
            prem_d = {prem_d[RW-1:0], dvd_d[DW-1]};
            dvd_d  = {dvd_d[DW-2:0], 1'b0};
            if (prem_d >= {1'b0, dvs_d}) begin
              prem_d = prem_d - {1'b0, dvs_d};
              quo_d  = {quo_d[DW-2:0], 1'b1};
            end else begin
              quo_d  = {quo_d[DW-2:0], 1'b0};
            end
          end
        end
      end
    end

    always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
        prem_q <= '0;
        dvd_q  <= '0;
        quo_q  <= '0;
        dvs_q  <= '0;
        tag_q  <= '0;
        dz_q   <= 1'b0;
      end else begin
        prem_q <= prem_d;
        dvd_q  <= dvd_d;
        quo_q  <= quo_d;
        dvs_q  <= dvs_d;
        tag_q  <= tag_d;
        dz_q   <= dz_d;
      end
    end

    assign chain_prem[k+1] = prem_q;
    assign chain_dvd[k+1]  = dvd_q;
    assign chain_quo[k+1]  = quo_q;
    assign chain_dvs[k+1]  = dvs_q;
    assign chain_tag[k+1]  = tag_q;
    assign chain_dz[k+1]   = dz_q;
  end

  assign in_ready    = adv_c[0];
  assign out_valid   = vld_q[NSTAGES-1];
  assign quotient    = chain_quo[NSTAGES];
  assign remainder   = chain_prem[NSTAGES][RW-1:0];
  assign out_tag     = chain_tag[NSTAGES];
  assign div_by_zero = chain_dz[NSTAGES];

endmodule

// File: tb/tb_pipelined_divider.sv
// Scoreboarded bench: default-parameter divider with directed vectors, plus a
// small 3/2/1 instance swept over every operand pair with random out_ready.
module tb_pipelined_divider;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetN;
  logic       in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [7:0] dividend, quotient;
  logic [3:0] divisor, remainder, in_tag, out_tag;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_dz;
  logic [2:0] b_dividend, b_quotient;
  logic [1:0] b_divisor, b_remainder;
  logic [3:0] b_in_tag, b_out_tag;

  pipelined_divider dut (
    .clock(clock), .resetN(resetN),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .out_tag(out_tag),
    .div_by_zero(div_by_zero)
  );

  pipelined_divider #(.DIVIDENDLEN(3), .DIVISORLEN(2), .SLICES_PER_STAGE(1), .TAGLEN(4)) dut_b (
    .clock(clock), .resetN(resetN),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .dividend(b_dividend), .divisor(b_divisor), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .quotient(b_quotient), .remainder(b_remainder), .out_tag(b_out_tag),
    .div_by_zero(b_dz)
  );

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic [3:0] t;
    logic       dz;
  } exp_t;

  typedef struct packed {
    logic [2:0] q;
    logic [1:0] r;
    logic [3:0] t;
    logic       dz;
  } expb_t;

  exp_t  sb[$];
  expb_t sbb[$];
  int    checks = 0;
  int    errors = 0;
  int    acc    = 0;
  int    waited;
  int    dummy;
  logic  rand_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor for the default instance.
  always @(negedge clock) begin
    exp_t e;
    if (resetN && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("a_unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("a_quotient", 32'(quotient), 32'(e.q));
        check("a_remainder", 32'(remainder), 32'(e.r));
        check("a_tag", 32'(out_tag), 32'(e.t));
        check("a_dz", 32'(div_by_zero), 32'(e.dz));
      end
    end
  end

  // Monitor for the small instance.
  always @(negedge clock) begin
    expb_t e;
    if (resetN && b_out_valid && b_out_ready) begin
      if (sbb.size() == 0) begin
        check("b_unexpected_result", 32'(b_out_valid), 32'd0);
      end else begin
        e = sbb.pop_front();
        check("b_quotient", 32'(b_quotient), 32'(e.q));
        check("b_remainder", 32'(b_remainder), 32'(e.r));
        check("b_tag", 32'(b_out_tag), 32'(e.t));
        check("b_dz", 32'(b_dz), 32'(e.dz));
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (rand_en) b_out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [3:0] b, input logic [3:0] t,
                       input logic [7:0] eq, input logic [3:0] er, input logic edz,
                       output int w);
    exp_t e;
    bit   ok = 1'b0;
    in_valid = 1'b1; dividend = a; divisor = b; in_tag = t;
    w = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1'b1; break; end
      w++;
    end
    if (!ok) begin
      check("a_accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.q = eq; e.r = er; e.t = t; e.dz = edz;
      sb.push_back(e);
      acc++;
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_b(input logic [2:0] a, input logic [1:0] b);
    expb_t e;
    bit    ok = 1'b0;
    b_in_valid = 1'b1; b_dividend = a; b_divisor = b; b_in_tag = {a[1:0], b};
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (b_in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("b_accept_timeout", 32'(b_in_ready), 32'd1);
    end else begin
      e.q  = (b == 2'd0) ? 3'd7 : 3'(a / 3'(b));
      e.r  = (b == 2'd0) ? a[1:0] : 2'(a % 3'(b));
      e.t  = {a[1:0], b};
      e.dz = (b == 2'd0);
      sbb.push_back(e);
    end
    @(posedge clock); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
    check(name, 32'(sb.size()), 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    resetN = 1'b0;
    in_valid = 1'b0; dividend = '0; divisor = '0; in_tag = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_dividend = '0; b_divisor = '0; b_in_tag = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 resetN = 1'b1;

    // Reset state
    @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    @(posedge clock); #1;

    // 100/7 tag 3: result appears in the fourth cycle after in_valid rises
    begin
      exp_t e;
      e.q = 8'd14; e.r = 4'd2; e.t = 4'd3; e.dz = 1'b0;
      sb.push_back(e);
    end
    in_valid = 1'b1; dividend = 8'd100; divisor = 4'd7; in_tag = 4'd3;
    @(negedge clock);
    check("lat_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("lat_not_yet", 32'(out_valid), 32'd0);
    end
    @(negedge clock);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    @(posedge clock); #1;
    drain("lat_drain");

    // Back-to-back issue, results on consecutive cycles
    issue(8'd255, 4'd1, 4'd1, 8'd255, 4'd0, 1'b0, waited);
    check("b2b_ready0", 32'(waited), 32'd0);
    issue(8'd255, 4'd15, 4'd2, 8'd17, 4'd0, 1'b0, waited);
    check("b2b_ready1", 32'(waited), 32'd0);
    issue(8'd0, 4'd9, 4'd3, 8'd0, 4'd0, 1'b0, waited);
    check("b2b_ready2", 32'(waited), 32'd0);
    for (int i = 0; i < 30 && !out_valid; i++) @(negedge clock);
    check("b2b_first", 32'(out_valid), 32'd1);
    @(negedge clock);
    check("b2b_second", 32'(out_valid), 32'd1);
    @(negedge clock);
    check("b2b_third", 32'(out_valid), 32'd1);
    @(negedge clock);
    check("b2b_gap_after", 32'(out_valid), 32'd0);
    @(posedge clock); #1;

    // Divide by zero followed by a normal op
    issue(8'd13, 4'd0, 4'd5, 8'd255, 4'd13, 1'b1, waited);
    issue(8'd20, 4'd3, 4'd6, 8'd6, 4'd2, 1'b0, waited);
    drain("dz_drain");

    // Backpressure: only four fit, first result held stable
    out_ready = 1'b0;
    acc = 0;
    fork
      begin
        issue(8'd50, 4'd5, 4'd1, 8'd10, 4'd0, 1'b0, dummy);
        issue(8'd77, 4'd6, 4'd2, 8'd12, 4'd5, 1'b0, dummy);
        issue(8'd200, 4'd13, 4'd3, 8'd15, 4'd5, 1'b0, dummy);
        issue(8'd9, 4'd10, 4'd4, 8'd0, 4'd9, 1'b0, dummy);
        issue(8'd128, 4'd3, 4'd5, 8'd42, 4'd2, 1'b0, dummy);
        issue(8'd99, 4'd11, 4'd6, 8'd9, 4'd0, 1'b0, dummy);
      end
    join_none
    repeat (12) @(posedge clock);
    #1;
    check("bp_accepted", 32'(acc), 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_q", 32'(quotient), 32'd10);
      check("bp_hold_r", 32'(remainder), 32'd0);
      check("bp_hold_tag", 32'(out_tag), 32'd1);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && !(acc == 6 && sb.size() == 0); i++) @(negedge clock);
    wait fork;
    check("bp_accepted_all", 32'(acc), 32'd6);
    check("bp_drained", 32'(sb.size()), 32'd0);
    @(posedge clock); #1;

    // Asynchronous reset with operations in flight
    out_ready = 1'b0;
    issue(8'd30, 4'd4, 4'd7, 8'd7, 4'd2, 1'b0, waited);
    issue(8'd45, 4'd7, 4'd8, 8'd6, 4'd3, 1'b0, waited);
    issue(8'd60, 4'd9, 4'd9, 8'd6, 4'd6, 1'b0, waited);
    @(posedge clock);
    #3;
    check("mr_pre_valid", 32'(out_valid), 32'd1);
    resetN = 1'b0;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd1);
    check("mr_quotient", 32'(quotient), 32'd0);
    check("mr_remainder", 32'(remainder), 32'd0);
    check("mr_tag", 32'(out_tag), 32'd0);
    check("mr_dz", 32'(div_by_zero), 32'd0);
    sb.delete();
    @(posedge clock); #1;
    resetN = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("mr_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clock); #1;
    issue(8'd81, 4'd9, 4'd10, 8'd9, 4'd0, 1'b0, waited);
    drain("mr_after_drain");

    // Sweep every operand pair on the small instance
    rand_en = 1'b1;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 4; b++) begin
        issue_b(3'(a), 2'(b));
      end
    end
    for (int i = 0; i < 500 && sbb.size() != 0; i++) @(negedge clock);
    check("sweep_drained", 32'(sbb.size()), 32'd0);
    rand_en = 1'b0;
    @(posedge clock); #1;
    b_out_ready = 1'b1;
    repeat (4) @(negedge clock);
    check("sweep_idle", 32'(b_out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_divider.md
Name: pipelined_divider

Overview:
- Parametrised, pipelined unsigned restoring divider built from chained one-quotient-bit divider slices.
- SLICES_PER_STAGE slices are grouped between pipeline registers.
- Valid/ready handshake on input and output, with bubble-collapsing backpressure.
- Carries a user tag alongside each operation and flags divide-by-zero.
- Replaces the purely combinational slice chain as the arithmetic unit that the datapath instantiates.

Parameters:
- DIVIDENDLEN, 8, dividend and quotient width in bits (>=2).
- DIVISORLEN, 4, divisor and remainder width in bits (>=1, <=DIVIDENDLEN).
- SLICES_PER_STAGE, 2, slices (quotient bits) resolved per pipeline stage (1..DIVIDENDLEN).
- TAGLEN, 4, width of the pass-through tag.
- Derived localparam NSTAGES = ceil(DIVIDENDLEN/SLICES_PER_STAGE).

Ports:
- clock  input  1  rising-edge clock.
- resetN  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- dividend  input  DIVIDENDLEN  numerator.
- divisor  input  DIVISORLEN  denominator.
- in_tag  input  TAGLEN  opaque tag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- quotient  output  DIVIDENDLEN  quotient.
- remainder  output  DIVISORLEN  remainder.
- out_tag  output  TAGLEN  tag of this result.
- div_by_zero  output  1  divisor was 0 for this result.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - resetN low asynchronously clears every stage valid bit, so out_valid=0 and in_ready=1 after reset.
  - quotient, remainder, out_tag and div_by_zero reset to 0.
  - Stage data registers need not reset, but outputs are 0 while out_valid=0 after reset.
- Handshake:
  - A transfer occurs on a rising edge with in_valid&&in_ready (input) or out_valid&&out_ready (output).
  - Output data is held stable while out_valid&&!out_ready.
- Stage records:
  - Each stage holds: valid, partial remainder (DIVISORLEN+1 bits), remaining dividend bits, quotient bits so far, divisor, tag, dz.
- Slice operation (per quotient bit, MSB first):
  - Shift the next dividend bit into the partial remainder.
  - If partial >= divisor: subtract and emit quotient bit 1; else emit 0.
  - The final stage may hold fewer than SLICES_PER_STAGE slices when the division is not exact.
- Advance rule (bubble collapsing):
  - Stage k loads from stage k-1 iff stage k is empty, or stage k's contents leave this cycle.
  - The last stage's contents leave when out_ready=1.
  - in_ready = stage 0 may load by this rule, combinationally from out_ready and valid bits.
  - A stage whose predecessor is empty while it advances becomes empty (valid=0).
- Latency and throughput:
  - Latency is exactly NSTAGES cycles from input transfer to out_valid with no backpressure.
  - Throughput is 1 result per cycle.
  - Results emerge strictly in input order.
- Divide by zero:
  - divisor==0 gives quotient = all ones, remainder = dividend[DIVISORLEN-1:0], div_by_zero=1.
  - Same latency as a normal operation; does not disturb neighbouring operations.
- Width rule: remainder < divisor always for nonzero divisor; the quotient never overflows DIVIDENDLEN bits.
- Simultaneous events: input transfer and output transfer in the same cycle are both honoured; occupancy is unchanged.
- Capacity: holds at most NSTAGES operations. When full and out_ready=0, in_ready=0.
- Reset mid-operation: all in-flight operations are discarded; no partial result is ever presented.

Test Plan:
- Defaults, 100/7 tag 3 -> after exactly 4 cycles out_valid=1, quotient=14, remainder=2, out_tag=3, div_by_zero=0.
- 255/1, then 255/15, then 0/9 back-to-back -> consecutive cycles give (255,0), (17,0), (0,0) in order; in_ready stays 1.
- 13/0 -> quotient=255, remainder=13, div_by_zero=1; the following 20/3 still returns (6,2) with div_by_zero=0.
- Hold out_ready=0 while issuing 6 ops -> exactly 4 accepted, then in_ready=0 and the first result is held stable. Release out_ready -> all results drain in order; the remaining 2 are accepted as slots free.
- Issue 3 ops and pull resetN low asynchronously mid-cycle -> out_valid=0 and outputs 0 immediately, in_ready=1; no stale result appears after release.
- Exhaustive sweep with DIVIDENDLEN=3, DIVISORLEN=2, SLICES_PER_STAGE=1 over all 32 operand pairs with random out_ready -> every result matches the reference model (q=a/b, r=a%b; dz case as specified) in order.
